sa_skew_feeder: RTL and testbench

Input staging stage that sits directly upstream of the systolic array and drives its `input_left` bus. It accepts one activation vector per beat, with `DIMENSION` elements, through a valid/ready handshake. It delays lane `i` by `i` extra cycles so that the values enter the array as a diagonal wavefront. After the last beat it drains the skew pipeline with zeros and signals completion.

---
 rtl/sa_skew_feeder_if.sv | 32 +++
 rtl/sa_skew_feeder.sv | 120 ++++++++++++
 tb/tb_sa_skew_feeder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_skew_feeder_if.sv
// ============================================================================
//  sa_skew_feeder_if
//  Activation-beat handshake into the skew feeder and skewed bus out to the
//  array's input_left, with tile status.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sa_skew_feeder_if #(
  parameter int DIMENSION = 4,
  parameter int BIT_W     = 8
);
  logic [DIMENSION-1:0][BIT_W-1:0] in_data;
  logic                            in_valid;
  logic                            in_last;
  logic                            in_ready;
  logic [DIMENSION-1:0][BIT_W-1:0] out_left;
  logic                            busy;
  logic                            done;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, out_left, busy, done
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, out_left, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/sa_skew_feeder.sv
// ============================================================================
//  sa_skew_feeder
//  Delays lane i by i cycles so activation vectors enter the systolic array as
//  a diagonal wavefront; drains with zeros after the last beat and pulses done.
//  Optional global freeze input enabled by defining SA_FEED_STALL_EN.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_skew_feeder #(
  parameter int DIMENSION = 4,
  parameter int BIT_W     = 8
) (
  input  wire logic       clk,
  input  wire logic       rstn,
`ifdef SA_FEED_STALL_EN
  input  wire logic       stall,
`endif
  sa_skew_feeder_if.slave bus
);

  localparam int c_cnt_w = $clog2(DIMENSION);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(DIMENSION - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_flush_cnt;
  logic [c_cnt_w-1:0]   w_flush_cnt_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_stall;
  logic                 w_in_ready;
  logic                 w_accept;

`ifdef SA_FEED_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_in_ready   = (r_state != ST_FLUSH) && !w_stall;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;

  // Lane i is i+1 registers deep; non-accept cycles shift in zero bubbles.
  for (genvar gi = 0; gi < DIMENSION; gi++) begin : g_lane
    logic [BIT_W-1:0] r_stage [0:gi];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k <= gi; k++) begin
          r_stage[k] <= '0;
        end
      end else if (!w_stall) begin
        r_stage[0] <= w_accept ? bus.in_data[gi] : '0;
        for (int k = 1; k <= gi; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end

    assign bus.out_left[gi] = r_stage[gi];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_done      <= 1'b0;
    end else if (!w_stall) begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_done_nxt      = 1'b0;
    case (r_state)
      ST_IDLE, ST_STREAM: begin
        if (w_accept) begin
          if (bus.in_last) begin
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = c_cnt_init;
          end else begin
            w_state_nxt     = ST_STREAM;
          end
        end
      end
      ST_FLUSH: begin
        // done lands in the cycle the final element exits the deepest lane.
        if (r_flush_cnt == c_cnt_last) begin
          w_state_nxt     = ST_IDLE;
          w_flush_cnt_nxt = '0;
          w_done_nxt      = 1'b1;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sa_skew_feeder.sv
// ============================================================================
//  tb_sa_skew_feeder
//  Randomized bench with a cycle-history reference model for sa_skew_feeder.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_skew_feeder;

  localparam int D   = 4;
  localparam int W   = 8;
  localparam int N   = D * W;
  localparam int FAR = 1 << 30;

  logic clk = 1'b0;
  logic rstn;
  logic stall;

  always #5 clk = ~clk;

  sa_skew_feeder_if #(.DIMENSION(D), .BIT_W(W)) bus ();

  sa_skew_feeder #(.DIMENSION(D), .BIT_W(W)) u_dut (
    .clk   (clk),
    .rstn  (rstn),
`ifdef SA_FEED_STALL_EN
    .stall (stall),
`endif
    .bus   (bus)
  );

  // Reference model: beats[t] is the vector accepted at effective cycle t;
  // effective time advances only on edges where the feeder is not frozen.
  logic [N-1:0] beats [int];
  int           e;
  int           t_first;
  int           t_last;
  bit           open_tile;
  bit           last_acc;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h (eff cycle %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [N-1:0] exp_out();
    logic [N-1:0] r;
    logic [N-1:0] b;
    r = '0;
    for (int i = 0; i < D; i++) begin
      if (beats.exists(e - 1 - i)) begin
        b = beats[e - 1 - i];
        r[i*W +: W] = b[i*W +: W];
      end
    end
    return r;
  endfunction

  function automatic bit exp_ready(input bit s);
    return !s && !(e > t_last && e <= t_last + D - 1);
  endfunction

  task automatic model_clear();
    beats.delete();
    t_first   = FAR;
    t_last    = -1000;
    open_tile = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [N-1:0] d, input bit l, input bit s);
    bit rdy;
    bit acc;
    @(negedge clk);
    check("out_left", bus.out_left, exp_out());
    check("busy", N'(bus.busy), N'(t_first != FAR && e > t_first && e < t_last + D));
    check("done", N'(bus.done), N'(e == t_last + D));
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    stall        = s;
    #1;
    rdy = exp_ready(s);
    check("in_ready", N'(bus.in_ready), N'(rdy));
    acc = v && rdy;
    last_acc = acc;
    if (!s) begin
      if (acc) begin
        beats[e] = d;
        if (!open_tile) begin
          t_first   = e;
          open_tile = 1'b1;
          t_last    = FAR;
        end
        if (l) begin
          t_last    = e;
          open_tile = 1'b0;
        end
      end
      e++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [N-1:0] pd;
  bit           pv, pl, ps;

  initial begin
    vectors     = 0;
    miscompares = 0;
    e           = 0;
    last_acc    = 1'b0;
    model_clear();
    rstn         = 1'b0;
    stall        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
    #12;
    check("rst_out_left", bus.out_left, '0);
    check("rst_busy", N'(bus.busy), '0);
    check("rst_done", N'(bus.done), '0);
    check("rst_in_ready", N'(bus.in_ready), N'(1));
    @(negedge clk);
    rstn = 1'b1;

    // Single last beat {4,3,2,1}.
    cycle(1'b1, 32'h04030201, 1'b1, 1'b0);
    idle(6);

    // Three back-to-back beats, last on the third.
    cycle(1'b1, 32'h04030201, 1'b0, 1'b0);
    cycle(1'b1, 32'h08070605, 1'b0, 1'b0);
    cycle(1'b1, 32'h0c0b0a09, 1'b1, 1'b0);
    idle(6);

    // Bubble between two beats.
    cycle(1'b1, 32'ha4a3a2a1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 32'hb4b3b2b1, 1'b1, 1'b0);
    idle(6);

    // Beat held valid through FLUSH, accepted on the done cycle; stray last.
    cycle(1'b1, 32'h11223344, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h55667788, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(6);

    // Asynchronous reset in the middle of a flush.
    cycle(1'b1, 32'hdeadbeef, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    check("arst_out_left", bus.out_left, '0);
    check("arst_busy", N'(bus.busy), '0);
    check("arst_done", N'(bus.done), '0);
    model_clear();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    idle(4);
    cycle(1'b1, 32'hcafef00d, 1'b1, 1'b0);
    idle(6);

`ifdef SA_FEED_STALL_EN
    // Freeze for three cycles right after a single beat.
    cycle(1'b1, 32'h9a8b7c6d, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0, 1'b1);
    idle(6);
`endif

    // Randomized traffic honoring the hold-while-not-ready rule.
    pv = 1'b0;
    pl = 1'b0;
    pd = '0;
    for (int k = 0; k < 1500; k++) begin
`ifdef SA_FEED_STALL_EN
      ps = ($urandom_range(0, 7) == 0);
`else
      ps = 1'b0;
`endif
      if (!(pv && !last_acc)) begin
        pv = ($urandom_range(0, 3) != 0);
        pl = ($urandom_range(0, 5) == 0);
        pd = N'($urandom);
      end
      cycle(pv, pd, pl, ps);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
